// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Optional feature macro: MDU_DIV_EN (enables the divide datapath).
package mdu_pkg;

  localparam logic [4:0] ALU_MULT  = 5'd9;
  localparam logic [4:0] ALU_DIV   = 5'd10;
  localparam logic [4:0] ALU_MULTU = 5'd12;
  localparam logic [4:0] ALU_DIVU  = 5'd13;

  // One multiply or divide step per RUN cycle.
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// 64-bit shift/accumulate datapath: one radix-2 shift-add (multiply) or one
// restoring-divide step per cycle. Sign handling lives in mult_div_unit.
// Optional feature macro: MDU_DIV_EN (divide step present only when defined).
module mdu_iter_core #(
  parameter int W = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a_abs,
  input  logic [W-1:0]   b_abs,
  output logic [2*W-1:0] acc
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W:0]     mul_sum;
`ifdef MDU_DIV_EN
  logic [W:0]     rem_shift;
  logic [W:0]     trial;
`endif

  assign acc = acc_q;

  // Next accumulator: load operands, then one iteration per step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
`ifdef MDU_DIV_EN
    rem_shift = acc_q[2*W-1:W-1];
    trial     = rem_shift - {1'b0, opnd_q};
`endif
    if (load) begin
      // Multiply keeps the multiplier in the low half and the multiplicand aside;
      // divide keeps the dividend in the low half and the divisor aside.
      if (is_div) begin
        acc_d  = {{W{1'b0}}, a_abs};
        opnd_d = b_abs;
      end else begin
        acc_d  = {{W{1'b0}}, b_abs};
        opnd_d = a_abs;
      end
    end else if (step) begin
`ifdef MDU_DIV_EN
      if (is_div) begin
        // Borrow in bit W means the shifted remainder is below the divisor: restore.
        if (!trial[W]) acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        else           acc_d = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
      end else
`endif
      begin
        if (acc_q[0]) acc_d = {mul_sum, acc_q[W-1:1]};
        else          acc_d = {1'b0, acc_q[2*W-1:1]};
      end
    end
  end

  // Accumulator and held operand registers.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous here: RST is only looked at on the rising edge, like any data input.
    if (!RST) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// FSM IDLE -> RUN (32 steps) -> FIX (sign fix, HI/LO write) -> DONE (Done pulse).
// Optional feature macro: MDU_DIV_EN (div/divu accepted only when defined).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_width = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Start,
  input  logic [ALUControl_width-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]       SrcA,
  input  logic [DATA_WIDTH-1:0]       SrcB,
  input  logic                        MTHI,
  input  logic                        MTLO,
  output logic                        Busy,
  output logic                        Done,
  output logic [DATA_WIDTH-1:0]       HI,
  output logic [DATA_WIDTH-1:0]       LO
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITER_COUNT);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER_COUNT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;         // product / quotient sign
  logic            rem_neg_q, rem_neg_d; // remainder takes the dividend's sign
  logic            dbz_q, dbz_d;         // divide by zero forces LO to all ones

  logic            op_mult, op_multu, op_div, op_divu;
  logic            op_signed, op_is_div, op_valid;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_abs, b_abs;
  logic            core_load, core_step, core_is_div;
  logic [2*W-1:0]  core_acc, prod;
  logic [W-1:0]    quot, rem;

  assign op_mult  = (ALUControl == ALUControl_width'(ALU_MULT));
  assign op_multu = (ALUControl == ALUControl_width'(ALU_MULTU));
`ifdef MDU_DIV_EN
  assign op_div   = (ALUControl == ALUControl_width'(ALU_DIV));
  assign op_divu  = (ALUControl == ALUControl_width'(ALU_DIVU));
`else
  assign op_div   = 1'b0;
  assign op_divu  = 1'b0;
`endif
  assign op_signed = op_mult | op_div;
  assign op_is_div = op_div | op_divu;
  assign op_valid  = op_mult | op_multu | op_is_div;

  assign a_neg = op_signed & SrcA[W-1];
  assign b_neg = op_signed & SrcB[W-1];
  assign a_abs = a_neg ? -SrcA : SrcA;
  assign b_abs = b_neg ? -SrcB : SrcB;

  mdu_iter_core #(.W(W)) u_core (
    .CLK    (CLK),
    .RST    (RST),
    .load   (core_load),
    .step   (core_step),
    .is_div (core_is_div),
    .a_abs  (a_abs),
    .b_abs  (b_abs),
    .acc    (core_acc)
  );

  // Sign-corrected results from the unsigned magnitude accumulator.
  always_comb begin
    prod = neg_q ? -core_acc : core_acc;
    quot = neg_q ? -core_acc[W-1:0] : core_acc[W-1:0];
    rem  = rem_neg_q ? -core_acc[2*W-1:W] : core_acc[2*W-1:W];
  end

  // Next-state, counter, sign flags and HI/LO update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    dbz_d       = dbz_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    core_is_div = is_div_q;
    unique case (state_q)
      IDLE: begin
        if (Start && op_valid) begin
          // A valid Start wins over any simultaneous move.
          state_d     = RUN;
          count_d     = '0;
          busy_d      = 1'b1;
          is_div_d    = op_is_div;
          neg_d       = a_neg ^ b_neg;
          rem_neg_d   = a_neg;
          dbz_d       = op_is_div && (SrcB == '0);
          core_load   = 1'b1;
          core_is_div = op_is_div;
        end else begin
          if (MTHI) hi_d = SrcA;
          if (MTLO) lo_d = SrcA;
        end
      end
      RUN: begin
        core_step = 1'b1;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = dbz_q ? '1 : quot;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural registers; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
// Divide expectations follow MDU_DIV_EN the same way the design build does.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  alu_ctl;
  logic [31:0] src_a, src_b;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_hi, exp_lo;

  mult_div_unit #(.DATA_WIDTH(32), .ALUControl_width(5)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .Start      (start),
    .ALUControl (alu_ctl),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .MTHI       (mthi),
    .MTLO       (mtlo),
    .Busy       (busy),
    .Done       (done),
    .HI         (hi),
    .LO         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit code_valid(input logic [4:0] code);
`ifdef MDU_DIV_EN
    return code == 5'd9 || code == 5'd12 || code == 5'd10 || code == 5'd13;
`else
    return code == 5'd9 || code == 5'd12;
`endif
  endfunction

  // Architectural result {HI, LO} straight from the instruction semantics.
  function automatic logic [63:0] ref_result(input logic [4:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    int qa, qb;
    case (code)
      5'd9: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      5'd12: return {32'b0, a} * {32'b0, b};
      5'd10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
      5'd13: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {exp_hi, exp_lo};
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one Start from IDLE and follow it cycle by cycle to IDLE again.
  // noise: toggle Start/moves/operands while busy; mv_start: moves on the Start cycle.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit mv_start);
    logic [63:0] res;
    bit valid;
    valid = code_valid(code);
    res   = valid ? ref_result(code, a, b) : {exp_hi, exp_lo};
    start = 1'b1; alu_ctl = code; src_a = a; src_b = b;
    mthi = mv_start; mtlo = mv_start;
    tick();
    if (!valid) begin
      if (mv_start) begin exp_hi = a; exp_lo = a; end
      check("inv_busy", 64'(busy), 64'd0);
      check("inv_done", 64'(done), 64'd0);
      check("inv_hilo", {hi, lo}, {exp_hi, exp_lo});
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      tick();
      check("inv_busy2", 64'(busy), 64'd0);
      return;
    end
    for (int n = 1; n <= 33; n++) begin
      check($sformatf("busy_c%0d", n), 64'(busy), 64'd1);
      check($sformatf("done_c%0d", n), 64'(done), 64'd0);
      check($sformatf("hold_c%0d", n), {hi, lo}, {exp_hi, exp_lo});
      start   = noise ? 1'($urandom) : 1'b0;
      alu_ctl = noise ? 5'($urandom_range(9, 13)) : code;
      src_a   = $urandom;
      src_b   = $urandom;
      mthi    = noise ? 1'($urandom) : 1'b0;
      mtlo    = noise ? 1'($urandom) : 1'b0;
      tick();
    end
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check("done_c34", 64'(done), 64'd1);
    check("busy_c34", 64'(busy), 64'd0);
    check($sformatf("result op%0d a=%h b=%h", code, a, b), {hi, lo}, {exp_hi, exp_lo});
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    tick();
    check("done_c35", 64'(done), 64'd0);
    check("busy_c35", 64'(busy), 64'd0);
    check("hilo_c35", {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [4:0] codes [4] = '{5'd9, 5'd10, 5'd12, 5'd13};
    bit saw_done;

    rst_n = 1'b0; start = 1'b0; alu_ctl = '0; src_a = '0; src_b = '0;
    mthi = 1'b0; mtlo = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op(5'd9,  32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 1'b0);
    check("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(5'd10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_op(5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(5'd13, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0);
    run_op(5'd10, 32'hFFFF_FF9C, 32'h0000_0000, 1'b0, 1'b0);

    // Invalid code is ignored.
    run_op(5'd0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);

    // Moves in IDLE: MTLO alone, then both with an invalid-code Start.
    mtlo = 1'b1; src_a = 32'h0000_1234;
    tick();
    mtlo = 1'b0;
    exp_lo = 32'h0000_1234;
    check("mtlo_lo", 64'(lo), 64'(exp_lo));
    check("mtlo_hi", 64'(hi), 64'(exp_hi));
    run_op(5'd3, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    // A valid Start drops simultaneous moves; moves during busy are ignored.
    run_op(5'd9, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1);

    // Reset in the middle of a multiply.
    start = 1'b1; alu_ctl = 5'd9; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    rst_n = 1'b0;
    tick();
    exp_hi = '0; exp_lo = '0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_quiet", 64'(saw_done), 64'd0);
    run_op(5'd9, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);

    // Random operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      run_op(codes[$urandom_range(0, 3)], pick_operand(), pick_operand(),
             1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the multicycle MIPS datapath, sitting directly downstream of the ALU control decode alongside the main ALU. It consumes the 5-bit ALU control code and, for mult/multu/div/divu, runs a 32-iteration shift-add or restoring-divide sequence on the two ALU source operands. Results land in architectural HI/LO registers, which are read by mfhi/mflo. It also accepts direct mthi/mtlo writes.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width
- ALUControl_width, 5, width of ALU control code
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  synchronous, active-low reset
- Start  input  1  request; sampled only in IDLE
- ALUControl  input  ALUControl_width  operation code: 9 mult, 10 div, 12 multu, 13 divu
- SrcA  input  DATA_WIDTH  multiplicand / dividend (rs)
- SrcB  input  DATA_WIDTH  multiplier / divisor (rt)
- MTHI  input  1  write SrcA into HI
- MTLO  input  1  write SrcA into LO
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse; HI/LO hold the new result
- HI  output  DATA_WIDTH  HI register
- LO  output  DATA_WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE -> RUN requires Start=1 and a valid code (9/10/12/13). On entry, latch operands; for signed ops, latch absolute values and result signs. Count=0.
- Start with any other code is ignored; state stays IDLE.
- RUN: one iteration per cycle for 32 cycles, then go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX: apply sign correction and write HI/LO.
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - Go to DONE.
- DONE: Done=1 for one cycle, then return to IDLE unconditionally.
- Divide by zero: no trap. Run the full sequence; result is LO=0xFFFFFFFF, HI=dividend (SrcA as latched).
- Signed overflow, -2^31 / -1: LO=0x80000000, HI=0.
- MTHI/MTLO:
  - Take effect only in IDLE, with Start=0 or an invalid code.
  - Ignored while Busy and in DONE.
  - MTHI and MTLO together write both registers.
  - Start with a valid code in the same cycle wins; the moves are dropped.
- Operand changes after the Start cycle have no effect.
- Outputs from registers only; no combinational path from inputs to outputs.

## Timing
- Reset (RST=0 at an edge):
  - State=IDLE; Busy=0, Done=0, HI=0, LO=0; counter and accumulators cleared.
  - Reset mid-operation aborts and discards the partial result.
- Start accepted at edge 0:
  - Busy=1 from cycle 1 through cycle 33.
  - HI/LO updated at the end of cycle 33.
  - Done=1 and Busy=0 in cycle 34.
  - IDLE in cycle 35; the earliest next Start is sampled at edge 35.
- Fixed latency of 34 cycles for every valid op, including divide by zero.
- HI/LO are stable except at the FIX write and at accepted MTHI/MTLO writes.

## Configuration
- MDU_DIV_EN:
  - Defined: div/divu supported as above.
  - Undefined: divide datapath omitted. Codes 10/13 are treated as invalid, so Start is ignored, no Busy, and HI/LO are unchanged. Multiply behaviour and latency are unchanged.

## Structure
- Package mdu_pkg holds:
  - Code constants ALU_MULT=9, ALU_DIV=10, ALU_MULTU=12, ALU_DIVU=13.
  - State enum {IDLE, RUN, FIX, DONE}.
  - Iteration count constant 32.
- One sub-module, mdu_iter_core: the 64-bit shift/accumulate datapath (per-cycle add-shift or subtract-restore step). The FSM, counter, sign logic and HI/LO registers stay in mult_div_unit.

## Test plan
- mult 0xFFFFFFFF × 0x00000005 -> Done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFFB.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 0x00000064 / 0 -> cycle 34 Done, LO=0xFFFFFFFF, HI=0x00000064.
- RST=0 at cycle 10 of a mult -> next cycle Busy=0, HI=LO=0, no Done. After release, Start is accepted and completes normally.
- Start with ALUControl=0 -> Busy stays 0. mult in flight with MTHI=1 -> HI unchanged until FIX. MTLO in IDLE with SrcA=0x1234 -> LO=0x1234 next cycle.
